prog_encoder: RTL and testbench

Sequential RISC-V instruction encoder and instruction-memory loader for the single-cycle core. It accepts symbolic instruction requests (kind, registers, immediate) over a valid/ready handshake. It packs each request into a 32-bit RV32I word for the four opcode classes the core's control path executes: lw, sw, R-type and beq. It then writes the words to consecutive instruction-memory addresses. It is used by the test harness and the boot path to build programs in instruction memory without hand-assembled hex.

---
 rtl/prog_encoder_if.sv | 41 ++++
 rtl/prog_encoder.sv | 168 ++++++++++++++++
 tb/tb_prog_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_encoder_if.sv
// ============================================================================
// Module      : prog_encoder_if
// Description : Request channel and instruction-memory write port of the
//               program encoder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              req_last;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Request source; it also observes the memory writes the encoder issues.
    modport master (
        output req_valid, req_kind, req_funct3, req_funct7b5,
               req_rd, req_rs1, req_rs2, req_imm, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_kind, req_funct3, req_funct7b5,
               req_rd, req_rs1, req_rs2, req_imm, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/prog_encoder.sv
// ============================================================================
// Module      : prog_encoder
// Description : Packs symbolic lw/sw/R-type/beq requests into RV32I words and
//               writes them to consecutive instruction-memory addresses.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_encoder #(
    parameter int ADDR_W = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    prog_encoder_if.slave      bus,
    output logic [ADDR_W:0]    count,
    output logic               full,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ENC  = 3'd1;
    localparam logic [2:0] c_WR   = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    localparam logic [1:0] c_KIND_LW  = 2'b00;
    localparam logic [1:0] c_KIND_SW  = 2'b01;
    localparam logic [1:0] c_KIND_R   = 2'b10;
    localparam logic [1:0] c_KIND_BEQ = 2'b11;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_BEQ_ODD = 2'b01;
    localparam logic [1:0] c_ERR_RANGE   = 2'b10;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [ADDR_W:0] c_CAPACITY = (ADDR_W+1)'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [1:0]        r_kind;
    logic [2:0]        r_funct3;
    logic              r_funct7b5;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [12:0]       r_imm;
    logic              r_last;
    logic [31:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_err_code;

    logic              w_full;
    logic              w_ready;
    logic              w_accept;
    logic [31:0]       w_word;
    logic [1:0]        w_chk;

    assign w_full   = (r_count == c_CAPACITY);
    // Ready is also held low while rst is high so the reset cycle never accepts.
    assign w_ready  = (r_state == c_IDLE) & ~start & ~rst & ~w_full;
    assign w_accept = bus.req_valid & w_ready;

    always_comb begin
        w_word = 32'd0;
        case (r_kind)
            c_KIND_LW:  w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, c_OP_LOAD};
            c_KIND_SW:  w_word = {r_imm[11:5], r_rs2, r_rs1, 3'b010,
                                  r_imm[4:0], c_OP_STORE};
            c_KIND_R:   w_word = {1'b0, r_funct7b5, 5'b00000, r_rs2, r_rs1,
                                  r_funct3, r_rd, c_OP_REG};
            c_KIND_BEQ: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b000,
                                  r_imm[4:1], r_imm[11], c_OP_BRANCH};
            default:    w_word = 32'd0;
        endcase
    end

    // lw/sw offsets must fit a signed 12-bit field; beq targets are halfword aligned.
    always_comb begin
        w_chk = c_ERR_NONE;
        if (r_kind == c_KIND_BEQ && r_imm[0]) begin
            w_chk = c_ERR_BEQ_ODD;
        end else if ((r_kind == c_KIND_LW || r_kind == c_KIND_SW) &&
                     (r_imm[12] != r_imm[11])) begin
            w_chk = c_ERR_RANGE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_state    <= c_IDLE;
            r_kind     <= 2'b00;
            r_funct3   <= 3'b000;
            r_funct7b5 <= 1'b0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_imm      <= 13'd0;
            r_last     <= 1'b0;
            r_word     <= 32'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_err_code <= c_ERR_NONE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_kind     <= bus.req_kind;
                        r_funct3   <= bus.req_funct3;
                        r_funct7b5 <= bus.req_funct7b5;
                        r_rd       <= bus.req_rd;
                        r_rs1      <= bus.req_rs1;
                        r_rs2      <= bus.req_rs2;
                        r_imm      <= bus.req_imm;
                        r_last     <= bus.req_last;
                        r_state    <= c_ENC;
                    end
                end
                c_ENC: begin
                    if (w_chk != c_ERR_NONE) begin
                        r_err_code <= w_chk;
                        r_state    <= c_ERR;
                    end else begin
                        r_word  <= w_word;
                        r_we    <= 1'b1;
                        r_state <= c_WR;
                    end
                end
                c_WR: begin
                    r_we   <= 1'b0;
                    r_addr <= r_addr + 1'b1;
                    if (r_count != c_CAPACITY) begin
                        r_count <= r_count + 1'b1;
                    end
                    r_state <= r_last ? c_DONE : c_IDLE;
                end
                c_DONE, c_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_word;

    assign count    = r_count;
    assign full     = w_full;
    assign done     = (r_state == c_DONE);
    assign err      = (r_state == c_ERR);
    assign err_code = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_prog_encoder.sv
// ============================================================================
// Module      : tb_prog_encoder
// Description : Self-checking bench for prog_encoder (4-word memory).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_encoder;

    localparam int c_AW  = 2;
    localparam int c_CAP = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [c_AW:0]    count;
    logic             full;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    prog_encoder_if #(.ADDR_W(c_AW)) bus ();

    prog_encoder #(.ADDR_W(c_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        int          imm;
        logic [31:0] word;
        logic [1:0]  ecode;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding, assembled from field values by arithmetic.
    function automatic logic [31:0] ref_word(input logic [1:0] kind, input int f3, input int f7,
                                             input int rd, input int rs1, input int rs2, input int imm);
        int u;
        u = imm & 'h1FFF;
        case (kind)
            2'b00:   return 32'((u & 'hFFF) * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + 3);
            2'b01:   return 32'(((u / 32) & 'h7F) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                                + 2 * (1 << 12) + (u % 32) * (1 << 7) + 'h23);
            2'b10:   return 32'(f7 * (1 << 30) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                                + rd * (1 << 7) + 'h33);
            default: return 32'(longint'((u / 4096) % 2) * (64'd1 << 31) + ((u / 32) % 64) * (1 << 25)
                                + rs2 * (1 << 20) + rs1 * (1 << 15) + ((u / 2) % 16) * (1 << 8)
                                + ((u / 2048) % 2) * (1 << 7) + 'h63);
        endcase
    endfunction

    function automatic logic [1:0] ref_err(input logic [1:0] kind, input int imm);
        if (kind == 2'b11 && (imm % 2) != 0) return 2'b01;
        if (kind <= 2'b01 && (imm < -2048 || imm > 2047)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_req(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int imm, input logic last);
        bus.req_kind     = kind;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_rd       = rd;
        bus.req_rs1      = rs1;
        bus.req_rs2      = rs2;
        bus.req_imm      = 13'(imm);
        bus.req_last     = last;
        bus.req_valid    = 1'b1;
    endtask

    // Waits (bounded) for ready, then completes the handshake edge.
    task automatic accept(output bit ok);
        int k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (bus.req_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got ready=%0b, expected 1", bus.req_ready);
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
    endtask

    // Full transaction; returns what was seen in the write cycle, ends in cycle N+3.
    task automatic do_req(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input int imm, input logic last,
                          output logic we, output logic [31:0] wd, output logic [c_AW-1:0] wa,
                          output logic e, output logic [1:0] ec);
        bit ok;
        set_req(kind, f3, f7, rd, rs1, rs2, imm, last);
        accept(ok);
        bus.req_valid = 1'b0;
        we = 1'b0; wd = '0; wa = '0; e = 1'b0; ec = 2'b00;
        if (ok) begin
            chk("enc_we", bus.imem_we, 1'b0);
            chk("enc_ready", bus.req_ready, 1'b0);
            tick();
            we = bus.imem_we; wd = bus.imem_wdata; wa = bus.imem_addr;
            e  = err;         ec = err_code;
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        chk("start_ready", bus.req_ready, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        chk("start_count", count, '0);
        chk("start_err", {err, err_code, done}, 4'b0000);
        chk("start_we", bus.imem_we, 1'b0);
    endtask

    initial begin
        vec_t             vecs[9];
        logic             we, e;
        logic [31:0]      wd;
        logic [c_AW-1:0]  wa;
        logic [1:0]       ec;
        bit               ok;
        int               m_count, m_addr;
        bit               m_blocked;

        vecs[0] = '{2'b10, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 0,     32'h002081B3, 2'b00};
        vecs[1] = '{2'b00, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 8,     32'h00802283, 2'b00};
        vecs[2] = '{2'b01, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 8,     32'h00612423, 2'b00};
        vecs[3] = '{2'b11, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -4,    32'hFE208EE3, 2'b00};
        vecs[4] = '{2'b10, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 0,     32'h403100B3, 2'b00};
        vecs[5] = '{2'b00, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, -1,    32'hFFF12083, 2'b00};
        vecs[6] = '{2'b11, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 3,     32'h0,        2'b01};
        vecs[7] = '{2'b00, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 2048,  32'h0,        2'b10};
        vecs[8] = '{2'b01, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -2049, 32'h0,        2'b10};

        bus.req_valid = 1'b0;
        bus.req_kind = '0; bus.req_funct3 = '0; bus.req_funct7b5 = 1'b0;
        bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_imm = '0; bus.req_last = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_imem", {bus.imem_we, 2'(bus.imem_addr), bus.imem_wdata}, '0);
        chk("rst_status", {count, full, done, err, err_code}, '0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.req_ready, 1'b1);

        // First R-type after reset
        do_req(2'b10, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 0, 1'b0, we, wd, wa, e, ec);
        chk("r_we", we, 1'b1);
        chk("r_wdata", wd, 32'h002081B3);
        chk("r_addr", wa, 0);
        chk("r_count", count, 1);
        chk("r_ready_n3", bus.req_ready, 1'b1);

        // Table vectors, each from a fresh start
        for (int i = 0; i < 9; i++) begin
            pulse_start();
            do_req(vecs[i].kind, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].imm, 1'b0, we, wd, wa, e, ec);
            chk($sformatf("vec%0d_we", i), we, (vecs[i].ecode == 2'b00));
            if (vecs[i].ecode == 2'b00) chk($sformatf("vec%0d_wdata", i), wd, vecs[i].word);
            chk($sformatf("vec%0d_err", i), e, (vecs[i].ecode != 2'b00));
            chk($sformatf("vec%0d_code", i), ec, vecs[i].ecode);
            chk($sformatf("vec%0d_count", i), count, (vecs[i].ecode == 2'b00) ? 1 : 0);
        end

        // Back-to-back, second held off by ready, ending in done
        pulse_start();
        set_req(2'b00, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 8, 1'b0);
        accept(ok);
        set_req(2'b01, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 8, 1'b1);
        #1;
        chk("b2b_hold_ready1", bus.req_ready, 1'b0);
        tick();
        chk("b2b_lw_we", bus.imem_we, 1'b1);
        chk("b2b_lw_wdata", bus.imem_wdata, 32'h00802283);
        chk("b2b_lw_addr", bus.imem_addr, 0);
        chk("b2b_hold_ready2", bus.req_ready, 1'b0);
        tick();
        chk("b2b_lw_count", count, 1);
        accept(ok);
        bus.req_valid = 1'b0;
        tick();
        chk("b2b_sw_we", bus.imem_we, 1'b1);
        chk("b2b_sw_wdata", bus.imem_wdata, 32'h00612423);
        chk("b2b_sw_addr", bus.imem_addr, 1);
        chk("b2b_done_early", done, 1'b0);
        tick();
        repeat (3) tick();
        chk("b2b_done", done, 1'b1);
        chk("b2b_done_ready", bus.req_ready, 1'b0);
        chk("b2b_count", count, 2);

        // Odd beq: sticky error, valid held and never accepted
        pulse_start();
        set_req(2'b11, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 3, 1'b0);
        accept(ok);
        tick();
        chk("beq_odd_err", {err, err_code}, 3'b101);
        chk("beq_odd_we", bus.imem_we, 1'b0);
        repeat (5) tick();
        chk("beq_odd_sticky", {err, err_code, bus.req_ready, bus.imem_we}, 5'b10100);
        chk("beq_odd_count", count, 0);
        bus.req_valid = 1'b0;

        // Range error keeps count; start clears it
        pulse_start();
        do_req(2'b10, 3'd7, 1'b0, 5'd4, 5'd4, 5'd4, 0, 1'b0, we, wd, wa, e, ec);
        do_req(2'b00, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 'h800, 1'b0, we, wd, wa, e, ec);
        chk("range_code", ec, 2'b10);
        chk("range_count", count, 1);
        pulse_start();
        chk("range_clr_ready", bus.req_ready, 1'b1);

        // Fill all four words, then start wraps to address 0
        for (int i = 0; i < c_CAP; i++) begin
            do_req(2'b10, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 0, 1'b0, we, wd, wa, e, ec);
            chk($sformatf("fill%0d_addr", i), wa, i);
        end
        repeat (2) tick();
        chk("full_flag", full, 1'b1);
        chk("full_ready", bus.req_ready, 1'b0);
        chk("full_count", count, c_CAP);
        pulse_start();
        do_req(2'b10, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 0, 1'b0, we, wd, wa, e, ec);
        chk("after_full_addr", {we, wa}, {1'b1, 2'd0});

        // Reset during the write cycle drops the word
        set_req(2'b10, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 0, 1'b0);
        accept(ok);
        bus.req_valid = 1'b0;
        tick();
        chk("rstwr_we_before", bus.imem_we, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstwr_imem", {bus.imem_we, 2'(bus.imem_addr), bus.imem_wdata}, '0);
        chk("rstwr_status", {count, full, done, err, err_code}, '0);
        rst = 1'b0;

        // Start during the write cycle drops the word as well
        set_req(2'b10, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 0, 1'b0);
        accept(ok);
        bus.req_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("startwr", {bus.imem_we, count}, '0);

        // Randomized requests against the reference model
        pulse_start();
        m_count = 0; m_addr = 0; m_blocked = 1'b0;
        for (int it = 0; it < 200; it++) begin
            logic [1:0]  kind;
            int          imm, r;
            logic [4:0]  rd, rs1, rs2;
            logic [2:0]  f3;
            logic        f7, last;
            logic [1:0]  x_ec;
            if (m_blocked || m_count == c_CAP) begin
                chk("rnd_full", full, (m_count == c_CAP));
                pulse_start();
                m_count = 0; m_addr = 0; m_blocked = 1'b0;
            end
            kind = 2'($urandom_range(0, 3));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3 = 3'($urandom); f7 = 1'($urandom); last = ($urandom_range(0, 15) == 0);
            r = int'($urandom_range(0, 9));
            if (kind <= 2'b01) begin
                if (r < 8) imm = int'($urandom_range(0, 4095)) - 2048;
                else       imm = (r == 8) ? -int'($urandom_range(2049, 4096)) : int'($urandom_range(2048, 4095));
            end else if (kind == 2'b11) begin
                imm = 2 * (int'($urandom_range(0, 4095)) - 2048) + ((r == 9) ? 1 : 0);
            end else begin
                imm = int'($urandom_range(0, 8191)) - 4096;
            end
            x_ec = ref_err(kind, imm);
            do_req(kind, f3, f7, rd, rs1, rs2, imm, last, we, wd, wa, e, ec);
            chk("rnd_we", we, (x_ec == 2'b00));
            chk("rnd_code", {e, ec}, {(x_ec != 2'b00), x_ec});
            if (x_ec == 2'b00) begin
                chk("rnd_wdata", wd, ref_word(kind, int'(f3), int'(f7), int'(rd), int'(rs1), int'(rs2), imm));
                chk("rnd_addr", wa, m_addr);
                m_addr = (m_addr + 1) % c_CAP;
                m_count++;
                if (last) m_blocked = 1'b1;
                chk("rnd_done", done, last);
            end else begin
                m_blocked = 1'b1;
            end
            chk("rnd_count", count, m_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
